// File: rtl/b_cache_dout_map_pkg.sv
// b_cache_dout_map_pkg
// Shared definitions for the B-cache read-side mapper.
// Contents:
//   - Bout_* job mode codes (sampled from B_cache_out_sel on start)
//   - FSM state encodings for the read sequencer
//   - lane-select helpers used by the delivery data path
package b_cache_dout_map_pkg;

    typedef enum logic [3:0] {
        Bout_IDLE   = 4'b0000,
        Bout_RD_FWD = 4'b0001,
        Bout_RD_REV = 4'b0010,
        Bout_RD_NEG = 4'b0011
    } bout_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // The only mode that permutes lanes; all others take lane i from lane i.
    localparam logic [3:0] LANE_SEL_REV_MODE = 4'b0010;

    // True for the job modes that start a read sequence.
    function automatic logic mode_supported(input logic [3:0] mode);
        logic ok;
        case (mode)
            Bout_RD_FWD: ok = 1'b1;
            Bout_RD_REV: ok = 1'b1;
            Bout_RD_NEG: ok = 1'b1;
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Source lane within the B-cache word for output lane 'lane' of 'y' lanes.
    function automatic int unsigned lane_src(input logic [3:0] mode,
                                             input int unsigned lane,
                                             input int unsigned y);
        int unsigned src;
        if (mode == LANE_SEL_REV_MODE) begin
            src = y - 32'd1 - lane;
        end else begin
            src = lane;
        end
        return src;
    endfunction

endpackage

// File: rtl/b_cache_dout_map_skew.sv
// b_lane_skew
// Per-lane delivery register chain: one sampling stage that captures the
// mapped B-cache lane, followed by D skew stages, so lane i (D=i) appears
// i cycles after lane 0. Data and valid travel together; everything clears
// on the asynchronous reset.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_data, in_vld    mapped lane data (already zeroed when invalid)
//   out_data, out_vld  skewed lane data and valid toward the RSA
module b_lane_skew #(
    parameter int unsigned D  = 0,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_vld,
    output logic [DW-1:0] out_data,
    output logic          out_vld
);

    logic [DW:0] chain_d [D+1];
    logic [DW:0] chain_q [D+1];

    // Next value of each stage: stage 0 samples the input, others shift.
    always_comb begin
        chain_d[0] = {in_vld, in_data};
        for (int j = 1; j <= int'(D); j++) begin
            chain_d[j] = chain_q[j-1];
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j <= int'(D); j++) begin
                chain_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j <= int'(D); j++) begin
                chain_q[j] <= chain_d[j];
            end
        end
    end

    assign out_data = chain_q[D][DW-1:0];
    assign out_vld  = chain_q[D][DW];

endmodule

// File: rtl/b_cache_dout_map.sv
// b_cache_dout_map
// Sequences B-cache port-B reads for one job and delivers the rows, lane
// mapped (forward / reversed / negated) and diagonally skewed, to the RSA
// B-operand inputs.
// Ports:
//   clk, sys_rst        clock, asynchronous active-high reset
//   B_cache_out_sel     job mode, sampled with start
//   start               job request pulse (IDLE only, supported mode only)
//   base_addr, n_rows   first row address and number of rows
//   B_cache_enb/addrb   port-B read enable and address
//   B_cache_doutb       port-B read data (L lanes)
//   B_rsa_dout/valid    skewed lane data and per-lane valid (Y lanes)
//   seq_cnt_out         1-based row index being issued, 0 otherwise
//   busy, done          job in progress / one-cycle completion pulse
module b_cache_dout_map
    import b_cache_dout_map_pkg::*;
#(
    parameter int unsigned Y          = 4,
    parameter int unsigned L          = 4,
    parameter int unsigned RSA_DW     = 32,
    parameter int unsigned SEQ_CNT_DW = 10,
    parameter int unsigned B_CACHE_AW = 10,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    sys_rst,
    input  logic [3:0]              B_cache_out_sel,
    input  logic                    start,
    input  logic [B_CACHE_AW-1:0]   base_addr,
    input  logic [SEQ_CNT_DW-1:0]   n_rows,
    output logic                    B_cache_enb,
    output logic [B_CACHE_AW-1:0]   B_cache_addrb,
    input  logic [L*RSA_DW-1:0]     B_cache_doutb,
    output logic [Y*RSA_DW-1:0]     B_rsa_dout,
    output logic [Y-1:0]            B_rsa_valid,
    output logic [SEQ_CNT_DW-1:0]   seq_cnt_out,
    output logic                    busy,
    output logic                    done
);

    // DRAIN lasts RD_LAT+Y cycles: read latency plus the deepest lane skew.
    localparam logic [SEQ_CNT_DW-1:0] DRAIN_LAST = SEQ_CNT_DW'(RD_LAT + Y - 1);

    state_e                  state_q, state_d;
    logic [3:0]              mode_q, mode_d;
    logic [SEQ_CNT_DW-1:0]   rows_q, rows_d;
    logic [SEQ_CNT_DW-1:0]   seq_q, seq_d;
    logic [SEQ_CNT_DW-1:0]   cnt_q, cnt_d;
    logic [B_CACHE_AW-1:0]   addr_q, addr_d;
    logic                    enb_q, enb_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic [RD_LAT-1:0]       rd_vld_q, rd_vld_d;
    logic [RSA_DW-1:0]       lane_data_s [Y];
    logic                    lane_vld_s;

    // Next-state and registered-output computation for the read sequencer.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rows_d  = rows_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        enb_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && mode_supported(B_cache_out_sel)) begin
                    mode_d = B_cache_out_sel;
                    rows_d = n_rows;
                    if (n_rows != '0) begin
                        state_d = ST_READ;
                        enb_d   = 1'b1;
                        addr_d  = base_addr;
                        seq_d   = SEQ_CNT_DW'(1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                // seq_q is the 1-based index of the row issued this cycle.
                if (seq_q == rows_q) begin
                    state_d = ST_DRAIN;
                    seq_d   = '0;
                    cnt_d   = '0;
                end else begin
                    enb_d  = 1'b1;
                    addr_d = addr_q + B_CACHE_AW'(1);
                    seq_d  = seq_q + SEQ_CNT_DW'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + SEQ_CNT_DW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    // Read-latency tracker: bit RD_LAT-1 marks the cycle doutb holds a row.
    always_comb begin
        rd_vld_d    = rd_vld_q << 1;
        rd_vld_d[0] = enb_q;
    end

    // Sequencer and control registers.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= '0;
            rows_q   <= '0;
            seq_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            enb_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rd_vld_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            rows_q   <= rows_d;
            seq_q    <= seq_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            enb_q    <= enb_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    // Lane mapping of the current doutb word; invalid lanes are forced to 0
    // so the skew chains only ever carry real data.
    always_comb begin
        lane_vld_s = rd_vld_q[RD_LAT-1];
        for (int i = 0; i < int'(Y); i++) begin
            if (!lane_vld_s) begin
                lane_data_s[i] = '0;
            end else if (mode_q == Bout_RD_NEG) begin
                lane_data_s[i] = {RSA_DW{1'b0}}
                    - B_cache_doutb[lane_src(mode_q, i, Y)*RSA_DW +: RSA_DW];
            end else begin
                lane_data_s[i] = B_cache_doutb[lane_src(mode_q, i, Y)*RSA_DW +: RSA_DW];
            end
        end
    end

    for (genvar i = 0; i < int'(Y); i++) begin : g_lane
        b_lane_skew #(
            .D  (i),
            .DW (RSA_DW)
        ) u_skew (
            .clk      (clk),
            .rst      (sys_rst),
            .in_data  (lane_data_s[i]),
            .in_vld   (lane_vld_s),
            .out_data (B_rsa_dout[i*RSA_DW +: RSA_DW]),
            .out_vld  (B_rsa_valid[i])
        );
    end

    assign B_cache_enb   = enb_q;
    assign B_cache_addrb = addr_q;
    assign seq_cnt_out   = seq_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_b_cache_dout_map.sv
// tb_b_cache_dout_map
// Self-checking bench for b_cache_dout_map: a behavioural B-cache port-B
// memory, a cycle-indexed reference model of each job (addresses, counters,
// lane values derived from the mode rules), a table of directed jobs with
// literal spot values, and randomized jobs.
module tb_b_cache_dout_map;
    import b_cache_dout_map_pkg::*;

    localparam int Y      = 4;
    localparam int L      = 4;
    localparam int DW     = 32;
    localparam int CW     = 10;
    localparam int AW     = 10;
    localparam int RD_LAT = 1;

    logic              clk;
    logic              sys_rst;
    logic [3:0]        B_cache_out_sel;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [CW-1:0]     n_rows;
    logic              B_cache_enb;
    logic [AW-1:0]     B_cache_addrb;
    logic [L*DW-1:0]   B_cache_doutb;
    logic [Y*DW-1:0]   B_rsa_dout;
    logic [Y-1:0]      B_rsa_valid;
    logic [CW-1:0]     seq_cnt_out;
    logic              busy;
    logic              done;

    b_cache_dout_map #(
        .Y(Y), .L(L), .RSA_DW(DW), .SEQ_CNT_DW(CW), .B_CACHE_AW(AW), .RD_LAT(RD_LAT)
    ) dut (
        .clk             (clk),
        .sys_rst         (sys_rst),
        .B_cache_out_sel (B_cache_out_sel),
        .start           (start),
        .base_addr       (base_addr),
        .n_rows          (n_rows),
        .B_cache_enb     (B_cache_enb),
        .B_cache_addrb   (B_cache_addrb),
        .B_cache_doutb   (B_cache_doutb),
        .B_rsa_dout      (B_rsa_dout),
        .B_rsa_valid     (B_rsa_valid),
        .seq_cnt_out     (seq_cnt_out),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // B-cache contents and its one-cycle-latency read port.
    logic [L*DW-1:0] mem [0:1023];
    always @(posedge clk or posedge sys_rst) begin
        if (sys_rst) B_cache_doutb <= '0;
        else if (B_cache_enb) B_cache_doutb <= mem[B_cache_addrb];
    end

    int checks = 0;
    int errors = 0;
    int last_done;
    logic [Y*DW-1:0] obs_dout [0:63];
    logic [AW-1:0]   obs_addr [0:63];
    logic [CW-1:0]   obs_seq  [0:63];

    typedef struct {
        logic [3:0]  mode;
        logic [9:0]  base;
        logic [9:0]  n;
        int          done_cyc;
        int          poke;
    } job_t;

    // sel 0..3 = lane data, 4 = addrb, 5 = seq_cnt_out
    typedef struct {
        int          job;
        int          cyc;
        int          sel;
        logic [31:0] val;
    } spot_t;

    job_t  jobs [6];
    spot_t spots [$];

    task automatic chk(input string nm, input int cyc, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Lane value the RSA must see for a given mode and B-cache word.
    function automatic logic [31:0] exp_lane(input logic [3:0] mode,
                                             input logic [L*DW-1:0] w, input int i);
        logic [31:0] x;
        case (mode)
            Bout_RD_REV: x = w[(Y-1-i)*DW +: DW];
            Bout_RD_NEG: x = 32'd0 - w[i*DW +: DW];
            default:     x = w[i*DW +: DW];
        endcase
        return x;
    endfunction

    // Issue one job and check every output on every cycle until one cycle
    // past done. poke >= 0 drives a conflicting start on that cycle.
    task automatic run_job(input logic [3:0] mode, input logic [9:0] base,
                           input logic [9:0] n, input int poke);
        int dc;
        int r;
        logic [9:0]  a;
        logic [31:0] ev;
        logic        ex_v;
        dc = (n == 10'd0) ? 0 : int'(n) + RD_LAT + Y;
        B_cache_out_sel = mode;
        base_addr       = base;
        n_rows          = n;
        start           = 1'b1;
        @(negedge clk);
        last_done = -1;
        for (int c = 0; c <= dc + 1; c++) begin
            if (c == poke) begin
                start = 1'b1;
                B_cache_out_sel = Bout_RD_FWD;
                base_addr = base + 10'd100;
                n_rows = 10'd7;
            end else begin
                start = 1'b0;
            end
            chk("enb", c, 128'(B_cache_enb), 128'(c < int'(n)));
            if (c < int'(n)) begin
                chk("addrb", c, 128'(B_cache_addrb), 128'(10'(base + 10'(c))));
            end else if (n != 10'd0) begin
                chk("addrb_hold", c, 128'(B_cache_addrb), 128'(10'(base + n - 10'd1)));
            end
            chk("seq_cnt", c, 128'(seq_cnt_out), (c < int'(n)) ? 128'(c + 1) : 128'(0));
            chk("done", c, 128'(done), 128'(c == dc));
            chk("busy", c, 128'(busy), 128'(c <= dc));
            for (int i = 0; i < Y; i++) begin
                r = c - RD_LAT - 1 - i;
                if (r >= 0 && r < int'(n)) begin
                    ex_v = 1'b1;
                    a    = base + 10'(r);
                    ev   = exp_lane(mode, mem[a], i);
                end else begin
                    ex_v = 1'b0;
                    ev   = 32'd0;
                end
                chk($sformatf("valid%0d", i), c, 128'(B_rsa_valid[i]), 128'(ex_v));
                chk($sformatf("lane%0d", i), c, 128'(B_rsa_dout[i*DW +: DW]), 128'(ev));
            end
            if (c < 64) begin
                obs_dout[c] = B_rsa_dout;
                obs_addr[c] = B_cache_addrb;
                obs_seq[c]  = seq_cnt_out;
            end
            if (done && last_done < 0) last_done = c;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [Y*DW-1:0] w;
        logic [31:0] act;
        sys_rst = 1'b1;
        start = 1'b0;
        B_cache_out_sel = 4'd0;
        base_addr = '0;
        n_rows = '0;
        for (int k = 0; k < 1024; k++) mem[k] = {$urandom, $urandom, $urandom, $urandom};
        mem[5]  = {32'd4, 32'd3, 32'd2, 32'd1};
        mem[6]  = {32'd8, 32'd7, 32'd6, 32'd5};
        mem[7]  = {32'd12, 32'd11, 32'd10, 32'd9};
        mem[20] = {32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd7};

        jobs[0] = '{Bout_RD_FWD, 10'd5,    10'd3, 8, -1};
        jobs[1] = '{Bout_RD_REV, 10'd5,    10'd1, 6, -1};
        jobs[2] = '{Bout_RD_NEG, 10'd20,   10'd1, 6, -1};
        jobs[3] = '{Bout_RD_FWD, 10'd1023, 10'd3, 8, -1};
        jobs[4] = '{Bout_RD_FWD, 10'd30,   10'd0, 0, -1};
        jobs[5] = '{Bout_RD_REV, 10'd40,   10'd2, 7, 1};

        spots.push_back('{0, 2, 0, 32'd1});
        spots.push_back('{0, 3, 0, 32'd5});
        spots.push_back('{0, 4, 0, 32'd9});
        spots.push_back('{0, 5, 3, 32'd4});
        spots.push_back('{0, 6, 3, 32'd8});
        spots.push_back('{0, 7, 3, 32'd12});
        spots.push_back('{0, 0, 4, 32'd5});
        spots.push_back('{0, 2, 4, 32'd7});
        spots.push_back('{1, 2, 0, 32'd4});
        spots.push_back('{1, 5, 3, 32'd1});
        spots.push_back('{2, 2, 0, 32'hFFFF_FFF9});
        spots.push_back('{2, 3, 1, 32'd0});
        spots.push_back('{2, 4, 2, 32'd1});
        spots.push_back('{2, 5, 3, 32'h8000_0000});
        spots.push_back('{3, 0, 4, 32'd1023});
        spots.push_back('{3, 1, 4, 32'd0});
        spots.push_back('{3, 2, 4, 32'd1});
        spots.push_back('{3, 0, 5, 32'd1});
        spots.push_back('{3, 2, 5, 32'd3});
        spots.push_back('{3, 3, 5, 32'd0});

        // Outputs while held in reset.
        repeat (3) @(negedge clk);
        chk("rst_enb",   0, 128'(B_cache_enb),   128'(0));
        chk("rst_addrb", 0, 128'(B_cache_addrb), 128'(0));
        chk("rst_seq",   0, 128'(seq_cnt_out),   128'(0));
        chk("rst_valid", 0, 128'(B_rsa_valid),   128'(0));
        chk("rst_dout",  0, 128'(B_rsa_dout),    128'(0));
        chk("rst_busy",  0, 128'(busy),          128'(0));
        chk("rst_done",  0, 128'(done),          128'(0));
        sys_rst = 1'b0;
        @(negedge clk);

        // Directed job table with literal spot values.
        for (int j = 0; j < 6; j++) begin
            run_job(jobs[j].mode, jobs[j].base, jobs[j].n, jobs[j].poke);
            chk("done_cycle", j, 128'(last_done), 128'(jobs[j].done_cyc));
            foreach (spots[s]) begin
                if (spots[s].job == j) begin
                    w = obs_dout[spots[s].cyc];
                    if (spots[s].sel < 4) act = w[spots[s].sel*DW +: DW];
                    else if (spots[s].sel == 4) act = 32'(obs_addr[spots[s].cyc]);
                    else act = 32'(obs_seq[spots[s].cyc]);
                    chk($sformatf("spot_j%0d_sel%0d", j, spots[s].sel), spots[s].cyc,
                        128'(act), 128'(spots[s].val));
                end
            end
        end

        // Start with Bout_IDLE or an unsupported code is ignored.
        for (int t = 0; t < 2; t++) begin
            B_cache_out_sel = (t == 0) ? 4'b0000 : 4'b0111;
            base_addr = 10'd3;
            n_rows = 10'd2;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("ign_busy", t, 128'(busy), 128'(0));
            chk("ign_enb",  t, 128'(B_cache_enb), 128'(0));
            chk("ign_done", t, 128'(done), 128'(0));
            @(negedge clk);
        end

        // Reset on cycle 3 of a 5-row job aborts it with no done.
        B_cache_out_sel = Bout_RD_FWD;
        base_addr = 10'd50;
        n_rows = 10'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", 3, 128'(busy), 128'(1));
        sys_rst = 1'b1;
        #1;
        chk("abort_enb",   3, 128'(B_cache_enb),   128'(0));
        chk("abort_addrb", 3, 128'(B_cache_addrb), 128'(0));
        chk("abort_seq",   3, 128'(seq_cnt_out),   128'(0));
        chk("abort_valid", 3, 128'(B_rsa_valid),   128'(0));
        chk("abort_dout",  3, 128'(B_rsa_dout),    128'(0));
        chk("abort_busy",  3, 128'(busy),          128'(0));
        chk("abort_done",  3, 128'(done),          128'(0));
        @(negedge clk);
        sys_rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            chk("post_abort_done",  c, 128'(done), 128'(0));
            chk("post_abort_busy",  c, 128'(busy), 128'(0));
            chk("post_abort_valid", c, 128'(B_rsa_valid), 128'(0));
            @(negedge clk);
        end
        run_job(Bout_RD_REV, 10'd60, 10'd4, -1);
        chk("post_abort_job_done", 0, 128'(last_done), 128'(4 + RD_LAT + Y));

        // Randomized jobs against the reference model.
        for (int t = 0; t < 12; t++) begin
            run_job(4'($urandom_range(1, 3)), 10'($urandom_range(0, 1023)),
                    10'($urandom_range(0, 6)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
